wb_arbiter: RTL and testbench

Writeback arbiter sitting between the execute/memory stages and the register file's write port (`we3`/`wa3`/`wd3`). It merges single-cycle ALU results with variable-latency load results into at most one register write per cycle. ALU results have priority; loads are buffered in a small FIFO. Writes addressed to the PC alias (all-ones address) are diverted to a dedicated PC write output. The arbiter exports a pending-register mask that decode uses to stall on outstanding loads.

---
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued load results into one
// register-file write per cycle, diverting PC-alias writes and tracking pending load targets.
module wb_arbiter #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int DEPTH        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [ADDRESSWIDTH-1:0]     alu_wa,
  input  logic [WIDTH-1:0]            alu_wd,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDRESSWIDTH-1:0]     ld_wa,
  input  logic [WIDTH-1:0]            ld_wd,
  output logic                        we3,
  output logic [ADDRESSWIDTH-1:0]     wa3,
  output logic [WIDTH-1:0]            wd3,
  output logic                        pc_we,
  output logic [WIDTH-1:0]            pc_wd,
  output logic [2**ADDRESSWIDTH-1:0]  pending_mask,
  output logic [$clog2(DEPTH+1)-1:0]  ld_count
);

  localparam int NREG = 2**ADDRESSWIDTH;
  localparam int CW   = $clog2(DEPTH+1);
  localparam int PW   = $clog2(DEPTH);
  localparam logic [CW-1:0]           FULL_COUNT = CW'(DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] PC_ADDR    = {ADDRESSWIDTH{1'b1}};

  // FIFO storage kept in flops: the kill check compares every entry in parallel.
  logic [DEPTH-1:0]        live_reg, live_next;
  logic [ADDRESSWIDTH-1:0] wa_reg   [DEPTH];
  logic [ADDRESSWIDTH-1:0] wa_next  [DEPTH];
  logic [WIDTH-1:0]        wd_reg   [DEPTH];
  logic [WIDTH-1:0]        wd_next  [DEPTH];

  logic [PW-1:0]           rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]           count_reg, count_next;

  logic                    we3_reg, pc_we_reg;
  logic [ADDRESSWIDTH-1:0] wa3_reg;
  logic [WIDTH-1:0]        wd3_reg, pc_wd_reg;
  logic [NREG-1:0]         mask_reg, mask_next;

  logic                    push, pop;
  logic                    issue_valid;
  logic [ADDRESSWIDTH-1:0] issue_wa;
  logic [WIDTH-1:0]        issue_wd;

  assign ld_ready = !reset && (count_reg < FULL_COUNT);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (count_reg != '0);

  always_comb begin
    issue_valid = 1'b0;
    issue_wa    = alu_wa;
    issue_wd    = alu_wd;
    if (alu_valid) begin
      issue_valid = 1'b1;
    end else if (pop && live_reg[rd_ptr_reg]) begin
      issue_valid = 1'b1;
      issue_wa    = wa_reg[rd_ptr_reg];
      issue_wd    = wd_reg[rd_ptr_reg];
    end
  end

  always_comb begin
    live_next = live_reg;
    for (int i = 0; i < DEPTH; i++) begin
      wa_next[i] = wa_reg[i];
      wd_next[i] = wd_reg[i];
      // Popped slots are cleared so vacant entries never contribute to the mask.
      if (pop && rd_ptr_reg == PW'(i))
        live_next[i] = 1'b0;
      if (alu_valid && wa_reg[i] == alu_wa)
        live_next[i] = 1'b0;
      if (push && wr_ptr_reg == PW'(i)) begin
        live_next[i] = !(alu_valid && ld_wa == alu_wa);
        wa_next[i]   = ld_wa;
        wd_next[i]   = ld_wd;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CW'(1);
    else if (!push && pop)
      count_next = count_reg - CW'(1);
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_mask
      logic [DEPTH-1:0] hit;
      for (gj = 0; gj < DEPTH; gj++) begin : g_hit
        assign hit[gj] = live_next[gj] && (wa_next[gj] == ADDRESSWIDTH'(gi));
      end
      assign mask_next[gi] = |hit;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      live_reg   <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      we3_reg    <= 1'b0;
      wa3_reg    <= '0;
      wd3_reg    <= '0;
      pc_we_reg  <= 1'b0;
      pc_wd_reg  <= '0;
      mask_reg   <= '0;
    end else begin
      live_reg  <= live_next;
      for (int i = 0; i < DEPTH; i++) begin
        wa_reg[i] <= wa_next[i];
        wd_reg[i] <= wd_next[i];
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      mask_reg  <= mask_next;

      we3_reg   <= issue_valid && (issue_wa != PC_ADDR);
      pc_we_reg <= issue_valid && (issue_wa == PC_ADDR);
      if (issue_valid && issue_wa == PC_ADDR) begin
        pc_wd_reg <= issue_wd;
      end else if (issue_valid) begin
        wa3_reg <= issue_wa;
        wd3_reg <= issue_wd;
      end
    end
  end

  assign we3          = we3_reg;
  assign wa3          = wa3_reg;
  assign wd3          = wd3_reg;
  assign pc_we        = pc_we_reg;
  assign pc_wd        = pc_wd_reg;
  assign pending_mask = mask_reg;
  assign ld_count     = count_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU writes, load drain, full FIFO, kills, PC alias, reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_wa;
  logic [15:0] alu_wd;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_wa;
  logic [15:0] ld_wd;
  logic        we3;
  logic [3:0]  wa3;
  logic [15:0] wd3;
  logic        pc_we;
  logic [15:0] pc_wd;
  logic [15:0] pending_mask;
  logic [2:0]  ld_count;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.WIDTH(16), .ADDRESSWIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
    .pending_mask(pending_mask), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic w, input logic [3:0] a, input logic [15:0] d);
    check({tag, ".we3"}, 32'(we3), 32'(w));
    if (w) begin
      check({tag, ".wa3"}, 32'(wa3), 32'(a));
      check({tag, ".wd3"}, 32'(wd3), 32'(d));
    end
    $display("step %s: we3=%0b wa3=%0d wd3=0x%04h pc_we=%0b mask=0x%04h count=%0d",
             tag, we3, wa3, wd3, pc_we, pending_mask, ld_count);
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    ld_valid = 1'b0; ld_wa = '0; ld_wd = '0;
    tick(); tick();
    check("rst.ld_ready", 32'(ld_ready), 0);
    check("rst.we3", 32'(we3), 0);
    check("rst.wa3", 32'(wa3), 0);
    check("rst.wd3", 32'(wd3), 0);
    check("rst.pc_we", 32'(pc_we), 0);
    check("rst.pc_wd", 32'(pc_wd), 0);
    check("rst.mask", 32'(pending_mask), 0);
    check("rst.count", 32'(ld_count), 0);
    reset = 1'b0;
    #1 check("rel.ld_ready", 32'(ld_ready), 1);

    // ALU only
    alu_valid = 1; alu_wa = 3; alu_wd = 16'h1234;
    tick(); alu_valid = 0;
    check_wr("alu", 1, 3, 16'h1234);
    check("alu.pc_we", 32'(pc_we), 0);
    tick();
    check_wr("alu_idle", 0, 0, 0);
    check("alu_idle.wa3_hold", 32'(wa3), 3);
    check("alu_idle.wd3_hold", 32'(wd3), 16'h1234);

    // Load drains only once ALU traffic stops
    alu_valid = 1; alu_wa = 1; alu_wd = 16'h1111;
    ld_valid = 1; ld_wa = 5; ld_wd = 16'hBEEF;
    tick(); ld_valid = 0;
    check_wr("pri1", 1, 1, 16'h1111);
    check("pri1.mask", 32'(pending_mask), 32'h0020);
    check("pri1.count", 32'(ld_count), 1);
    alu_wa = 2; alu_wd = 16'h2222;
    tick();
    check_wr("pri2", 1, 2, 16'h2222);
    check("pri2.mask", 32'(pending_mask), 32'h0020);
    alu_wa = 4; alu_wd = 16'h4444;
    tick(); alu_valid = 0;
    check_wr("pri3", 1, 4, 16'h4444);
    check("pri3.mask", 32'(pending_mask), 32'h0020);
    tick();
    check_wr("drain", 1, 5, 16'hBEEF);
    check("drain.mask", 32'(pending_mask), 0);
    check("drain.count", 32'(ld_count), 0);
    tick();
    check_wr("drain_idle", 0, 0, 0);

    // Full FIFO: four pushes under ALU traffic, fifth refused
    alu_valid = 1; alu_wa = 1; alu_wd = 16'h0101; ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ld_wa = 4'(8 + i); ld_wd = 16'hA008 + 16'(i);
      tick();
    end
    check("full.count", 32'(ld_count), 4);
    check("full.ld_ready", 32'(ld_ready), 0);
    check("full.mask", 32'(pending_mask), 32'h0F00);
    ld_wa = 12; ld_wd = 16'hDEAD;
    tick();
    check("full5.count", 32'(ld_count), 4);
    check("full5.mask", 32'(pending_mask), 32'h0F00);
    ld_valid = 0; alu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_wr($sformatf("full_drain%0d", i), 1, 4'(8 + i), 16'hA008 + 16'(i));
      check($sformatf("full_drain%0d.count", i), 32'(ld_count), 32'(3 - i));
      check($sformatf("full_drain%0d.ld_ready", i), 32'(ld_ready), 1);
    end
    tick();
    check_wr("full_idle", 0, 0, 0);
    check("full_idle.mask", 32'(pending_mask), 0);

    // Kill: ALU write to r6 overtakes queued r6 load
    alu_valid = 1; alu_wa = 1; alu_wd = 16'h0000;
    ld_valid = 1; ld_wa = 6; ld_wd = 16'h6666;
    tick();
    ld_wa = 7; ld_wd = 16'h7777;
    tick(); ld_valid = 0;
    check("kill.mask_pre", 32'(pending_mask), 32'h00C0);
    alu_wa = 6; alu_wd = 16'h0001;
    tick(); alu_valid = 0;
    check_wr("kill.alu", 1, 6, 16'h0001);
    check("kill.mask", 32'(pending_mask), 32'h0080);
    tick();
    check_wr("kill.discard", 0, 0, 0);
    check("kill.count", 32'(ld_count), 1);
    tick();
    check_wr("kill.r7", 1, 7, 16'h7777);
    check("kill.mask_post", 32'(pending_mask), 0);

    // Same-cycle push to the ALU's target is stored killed
    alu_valid = 1; alu_wa = 9; alu_wd = 16'h0909;
    ld_valid = 1; ld_wa = 9; ld_wd = 16'h9999;
    tick(); alu_valid = 0; ld_valid = 0;
    check_wr("skill.alu", 1, 9, 16'h0909);
    check("skill.mask", 32'(pending_mask), 0);
    check("skill.count", 32'(ld_count), 1);
    tick();
    check_wr("skill.discard", 0, 0, 0);
    check("skill.count0", 32'(ld_count), 0);

    // PC alias from ALU and from a drained load
    alu_valid = 1; alu_wa = 15; alu_wd = 16'h0040;
    tick(); alu_valid = 0;
    check("pc_alu.pc_we", 32'(pc_we), 1);
    check("pc_alu.pc_wd", 32'(pc_wd), 16'h0040);
    check("pc_alu.we3", 32'(we3), 0);
    check("pc_alu.wa3_hold", 32'(wa3), 9);
    ld_valid = 1; ld_wa = 15; ld_wd = 16'h0080;
    tick(); ld_valid = 0;
    check("pc_ld.mask", 32'(pending_mask), 32'h8000);
    check("pc_ld.pc_we_idle", 32'(pc_we), 0);
    tick();
    check("pc_ld.pc_we", 32'(pc_we), 1);
    check("pc_ld.pc_wd", 32'(pc_wd), 16'h0080);
    check("pc_ld.we3", 32'(we3), 0);
    check("pc_ld.mask0", 32'(pending_mask), 0);
    tick();
    check("pc_ld.pc_we_off", 32'(pc_we), 0);
    check("pc_ld.pc_wd_hold", 32'(pc_wd), 16'h0080);

    // Reset with three entries queued
    alu_valid = 1; alu_wa = 1; alu_wd = 16'h0111; ld_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ld_wa = 4'(2 + i); ld_wd = 16'hC000 + 16'(i);
      tick();
    end
    check("mid.count", 32'(ld_count), 3);
    check("mid.mask", 32'(pending_mask), 32'h001C);
    reset = 1; alu_valid = 0;
    #1 check("mid_rst.ld_ready", 32'(ld_ready), 0);
    tick();
    reset = 0; ld_valid = 0;
    check("mid_rst.count", 32'(ld_count), 0);
    check("mid_rst.mask", 32'(pending_mask), 0);
    check("mid_rst.we3", 32'(we3), 0);
    check("mid_rst.pc_we", 32'(pc_we), 0);
    check("mid_rst.wa3", 32'(wa3), 0);
    #1 check("mid_rel.ld_ready", 32'(ld_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_post%0d.we3", i), 32'(we3), 0);
      check($sformatf("mid_post%0d.pc_we", i), 32'(pc_we), 0);
      check($sformatf("mid_post%0d.count", i), 32'(ld_count), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
